ws2812_driver: RTL and testbench
================================

# ws2812_driver

Serial LED strand driver that sits directly downstream of the pattern generators. It walks an LED index, requests each LED's colour from the active pattern block, buffers one LED ahead, and serialises GRB data onto a single WS2812-style one-wire output with programmable bit timing. A latch/reset gap closes each frame.

## Interface
- NUM_LEDS, 20, LEDs on the strand (≥1)
- COLOR_WIDTH, 8, bits per colour channel; 3·COLOR_WIDTH bits are sent per LED
- T0H_CYCLES, 40, high time of a 0 bit, in clk cycles
- T1H_CYCLES, 80, high time of a 1 bit (T0H < T1H < TBIT)
- TBIT_CYCLES, 125, total bit period
- TRESET_CYCLES, 5000, low latch gap after the last LED
- CounterWidth (localparam), $clog2(NUM_LEDS), minimum 1
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-low reset
- start_in  in  1  begin a frame; sampled only in IDLE
- next_led_request  out  CounterWidth  LED index requested from the pattern block
- red_in, green_in, blue_in  in  COLOR_WIDTH each  colour for the requested LED
- color_valid_in  in  1  colour inputs valid
- strand_out  out  1  serial data to the strand, registered
- busy_out  out  1  high from leaving IDLE until frame_done_out
- frame_done_out  out  1  one-cycle pulse at the end of the reset gap
- underrun_out  out  1  one-cycle pulse when the next LED's colour is not ready

## Operation
- Reset (async assert, sync release): state IDLE, strand_out 0, next_led_request 0, busy_out 0, frame_done_out 0, underrun_out 0, holding register and valid flag cleared.
- Pattern sources have 1-cycle registered latency. A colour is captured only when color_valid_in is high on the 2nd or a later cycle after next_led_request last changed. A 2-cycle settle counter enforces this.
- IDLE: strand low, request 0. start_in high → PREFETCH.
- PREFETCH: capture LED 0 into the holding register. Then → SEND: load the shift register from the holding register, clear the holding valid flag, set led_idx 0, and set the request to 1 if NUM_LEDS>1.
- SEND: 3·COLOR_WIDTH bits, MSB first, order G, R, B.
  - Per-bit counter runs 0..TBIT−1.
  - strand_out is high while cnt < (bit ? T1H : T0H), otherwise low.
  - The next LED is captured into the holding register in parallel, once per LED.
- End of the last bit of an LED:
  - If led_idx = NUM_LEDS−1 → RESET_GAP.
  - Otherwise, if the holding register is valid: reload the shift register with no gap, increment led_idx, and advance the request. The request saturates at NUM_LEDS−1.
  - Otherwise: pulse underrun_out, abort the frame → RESET_GAP.
- RESET_GAP: strand low for TRESET cycles. Then pulse frame_done_out with busy_out low in the same cycle → IDLE.
- start_in outside IDLE is ignored. start_in high in the cycle after frame_done_out starts a new frame.
- Async reset mid-frame: strand_out drops to 0 immediately. No frame_done_out is produced.

## Timing
- start_in sampled at edge k. The PREFETCH capture is no earlier than edge k+2. The first strand rising edge is registered at the edge after entering SEND (≥ k+3).
- Bit period is exactly TBIT cycles. Inter-LED gap is 0 cycles in the no-underrun case.
- Frame duration: NUM_LEDS·3·COLOR_WIDTH·TBIT + TRESET + PREFETCH overhead (≥3) cycles.
- frame_done_out, underrun_out: exactly one cycle wide, registered.

## Structure
- Package led_pkg:
  - driver state enum (IDLE, PREFETCH, SEND, RESET_GAP)
  - GRB channel-order constant
  - default WS2812 timing constants at 100 MHz
- Sub-module ws2812_bit_encoder:
  - Inputs: bit_in, bit_start.
  - Outputs: strand, bit_done.
  - Owns the TBIT counter and the high-time compare.
  - The top level owns the FSM, shift/holding registers and request index.

## Test plan
- NUM_LEDS=3, COLOR_WIDTH=8, T0H=2, T1H=4, TBIT=6, TRESET=20, driven by the gradient pattern source, start pulse.
  - Decoded GRB: LED0 (0,0,255), LED1 (0,4,251), LED2 (0,8,247).
  - Then 20 low cycles, then frame_done_out.
- Single LED with G=0x80, R=B=0.
  - First bit: 4 high, 2 low.
  - Remaining 23 bits: 2 high, 4 low.
  - busy_out high throughout.
- color_valid_in forced low after LED0 is captured → underrun_out pulses at the end of LED0, strand low for TRESET, frame_done_out, back to IDLE.
- start_in held high through a frame → frame restarts only after frame_done_out. No mid-frame restart.
- rst_in asserted mid-SEND → strand_out, busy_out and next_led_request go to 0 asynchronously. After release, IDLE waits for start_in.
- NUM_LEDS=1 → next_led_request stays 0, one LED is sent, then reset gap and frame_done_out.

Source files
------------

// File: rtl/ws2812_driver_pkg.sv
// Shared types and constants for the WS2812 strand driver.
// Holds the FSM state enum, the on-wire channel order and 100 MHz default timings.
package led_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PREFETCH  = 2'd1,
    S_SEND      = 2'd2,
    S_RESET_GAP = 2'd3
  } drv_state_e;

  // Enum values double as indices into the {blue, green, red} channel vector
  typedef enum logic [1:0] {
    CH_RED   = 2'd0,
    CH_GREEN = 2'd1,
    CH_BLUE  = 2'd2
  } channel_e;

  localparam channel_e GRB_ORDER [3] = '{CH_GREEN, CH_RED, CH_BLUE};

  localparam int WS_T0H_100M    = 40;
  localparam int WS_T1H_100M    = 80;
  localparam int WS_TBIT_100M   = 125;
  localparam int WS_TRESET_100M = 5000;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ws2812_driver_if.sv
// Request/colour link between the strand driver (master) and a pattern source (slave).
// The source answers a request index with a colour one registered cycle later.
interface ws2812_driver_if #(
  parameter int NUM_LEDS    = 20,
  parameter int COLOR_WIDTH = 8
);
  localparam int CounterWidth = led_pkg::cnt_width(NUM_LEDS);

  logic [CounterWidth-1:0] next_led_request;
  logic [COLOR_WIDTH-1:0]  red_in;
  logic [COLOR_WIDTH-1:0]  green_in;
  logic [COLOR_WIDTH-1:0]  blue_in;
  logic                    color_valid_in;

  modport master (
    output next_led_request,
    input  red_in, green_in, blue_in, color_valid_in
  );

  modport slave (
    input  next_led_request,
    output red_in, green_in, blue_in, color_valid_in
  );
endinterface

// File: rtl/ws2812_bit_encoder.sv
// One-wire bit encoder: one TBIT-cycle period per bit, high for T0H or T1H cycles.
// bit_done marks the last cycle of a bit so the next bit can start without a gap.
module ws2812_bit_encoder #(
  parameter int T0H_CYCLES  = 40,
  parameter int T1H_CYCLES  = 80,
  parameter int TBIT_CYCLES = 125
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic bit_in,
  input  logic bit_start,
  output logic strand,
  output logic bit_done
);
  localparam int CntW = $clog2(TBIT_CYCLES);

  logic            r_active;
  logic            r_bit;
  logic [CntW-1:0] r_cnt;
  logic            r_strand;
  logic [CntW-1:0] w_nxt;
  logic [CntW-1:0] w_high_lim;

  assign w_nxt      = r_cnt + CntW'(1);
  assign w_high_lim = r_bit ? CntW'(T1H_CYCLES) : CntW'(T0H_CYCLES);
  assign bit_done   = r_active && (r_cnt == CntW'(TBIT_CYCLES - 1));
  assign strand     = r_strand;

  // r_strand always reflects the cycle that r_cnt currently counts
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_active <= 1'b0;
      r_bit    <= 1'b0;
      r_cnt    <= '0;
      r_strand <= 1'b0;
    end else if (bit_start) begin
      r_active <= 1'b1;
      r_bit    <= bit_in;
      r_cnt    <= '0;
      r_strand <= 1'b1;
    end else if (bit_done) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_strand <= 1'b0;
    end else if (r_active) begin
      r_cnt    <= w_nxt;
      r_strand <= (w_nxt < w_high_lim);
    end
  end
endmodule

// File: rtl/ws2812_driver.sv
// WS2812 strand driver: walks the LED index, prefetches one LED ahead into a holding
// register and streams GRB bits back-to-back, closing each frame with a low latch gap.
module ws2812_driver
  import led_pkg::*;
#(
  parameter int NUM_LEDS      = 20,
  parameter int COLOR_WIDTH   = 8,
  parameter int T0H_CYCLES    = WS_T0H_100M,
  parameter int T1H_CYCLES    = WS_T1H_100M,
  parameter int TBIT_CYCLES   = WS_TBIT_100M,
  parameter int TRESET_CYCLES = WS_TRESET_100M
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  ws2812_driver_if.master  pat_if,
  output logic             strand_out,
  output logic             busy_out,
  output logic             frame_done_out,
  output logic             underrun_out
);
  localparam int CounterWidth = cnt_width(NUM_LEDS);
  localparam int PixW         = 3 * COLOR_WIDTH;
  localparam int BitW         = $clog2(PixW);
  localparam int GapW         = $clog2(TRESET_CYCLES + 1);
  localparam logic [CounterWidth-1:0] LastLed = CounterWidth'(NUM_LEDS - 1);

  drv_state_e              r_state;
  logic [PixW-1:0]         r_hold;
  logic                    r_hold_vld;
  logic [PixW-2:0]         r_shift;
  logic [BitW-1:0]         r_bit_idx;
  logic [CounterWidth-1:0] r_led_idx;
  logic [CounterWidth-1:0] r_req;
  logic [1:0]              r_settle;
  logic [GapW-1:0]         r_gap;
  logic                    r_busy, r_done, r_underrun;

  logic [2:0][COLOR_WIDTH-1:0] w_chan;
  logic [PixW-1:0]             w_pix;
  logic                        w_bit_start, w_bit_in, w_bit_done, w_led_end;
  logic                        w_need, w_capture;
  logic [CounterWidth-1:0]     w_req_next;

  assign w_chan = {pat_if.blue_in, pat_if.green_in, pat_if.red_in};
  for (genvar g = 0; g < 3; g++) begin : g_order
    assign w_pix[(2-g)*COLOR_WIDTH +: COLOR_WIDTH] = w_chan[GRB_ORDER[g]];
  end

  // Source output is fresh from the second cycle after the request changed
  assign w_need     = (r_state == S_PREFETCH) || ((r_state == S_SEND) && (r_led_idx != LastLed));
  assign w_capture  = w_need && !r_hold_vld && (r_settle != 2'd0) && pat_if.color_valid_in;
  assign w_req_next = (r_req == LastLed) ? r_req : r_req + CounterWidth'(1);
  assign w_led_end  = w_bit_done && (r_bit_idx == BitW'(PixW - 1));

  always_comb begin
    w_bit_start = 1'b0;
    w_bit_in    = r_hold[PixW-1];
    case (r_state)
      S_PREFETCH: w_bit_start = r_hold_vld;
      S_SEND: if (w_bit_done) begin
        if (!w_led_end) begin
          w_bit_start = 1'b1;
          w_bit_in    = r_shift[PixW-2];
        end else if (r_led_idx != LastLed && r_hold_vld) begin
          w_bit_start = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= S_IDLE;
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_led_idx  <= '0;
      r_req      <= '0;
      r_settle   <= '0;
      r_gap      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
      if (r_settle != 2'd2) r_settle <= r_settle + 2'd1;
      if (w_capture) begin
        r_hold     <= w_pix;
        r_hold_vld <= 1'b1;
      end
      case (r_state)
        S_IDLE: if (start_in) begin
          r_state    <= S_PREFETCH;
          r_busy     <= 1'b1;
          r_settle   <= '0;
          r_hold_vld <= 1'b0;
        end
        S_PREFETCH: if (r_hold_vld) begin
          r_state    <= S_SEND;
          r_shift    <= r_hold[PixW-2:0];
          r_hold_vld <= 1'b0;
          r_bit_idx  <= '0;
          r_led_idx  <= '0;
          r_req      <= w_req_next;
          r_settle   <= '0;
        end
        S_SEND: if (w_bit_done) begin
          if (!w_led_end) begin
            r_shift   <= {r_shift[PixW-3:0], 1'b0};
            r_bit_idx <= r_bit_idx + BitW'(1);
          end else if (r_led_idx == LastLed) begin
            r_state <= S_RESET_GAP;
            r_gap   <= '0;
          end else if (r_hold_vld) begin
            r_shift    <= r_hold[PixW-2:0];
            r_hold_vld <= 1'b0;
            r_bit_idx  <= '0;
            r_led_idx  <= r_led_idx + CounterWidth'(1);
            r_req      <= w_req_next;
            r_settle   <= '0;
          end else begin
            r_underrun <= 1'b1;
            r_state    <= S_RESET_GAP;
            r_gap      <= '0;
          end
        end
        S_RESET_GAP: begin
          if (r_gap == GapW'(TRESET_CYCLES - 1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_req   <= '0;
          end else begin
            r_gap <= r_gap + GapW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  ws2812_bit_encoder #(
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES),
    .TBIT_CYCLES(TBIT_CYCLES)
  ) u_enc (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .bit_in   (w_bit_in),
    .bit_start(w_bit_start),
    .strand   (strand_out),
    .bit_done (w_bit_done)
  );

  assign pat_if.next_led_request = r_req;
  assign busy_out                = r_busy;
  assign frame_done_out          = r_done;
  assign underrun_out            = r_underrun;
endmodule

// File: tb/tb_ws2812_driver.sv
// Directed bench: a 3-LED strand fed by a gradient source and a 1-LED strand fed by a
// constant colour, both with T0H=2, T1H=4, TBIT=6, TRESET=20.
module tb_ws2812_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start3 = 1'b0, start1 = 1'b0;
  logic valid_en3 = 1'b1, valid_en1 = 1'b1;
  logic [7:0] g1 = '0, r1 = '0, bl1 = '0;
  logic s3, b3, d3, u3, s1, b1, d1, u1;

  int errors = 0;
  int checks = 0;

  logic wave [0:431];
  logic [23:0] led_word [0:2];
  int rise_lat, busy_low, ur_cnt, bad_bits, req1_bad;

  always #5 clk = ~clk;

  ws2812_driver_if #(.NUM_LEDS(3), .COLOR_WIDTH(8)) if3 ();
  ws2812_driver_if #(.NUM_LEDS(1), .COLOR_WIDTH(8)) if1 ();

  ws2812_driver #(.NUM_LEDS(3), .COLOR_WIDTH(8), .T0H_CYCLES(2), .T1H_CYCLES(4),
                  .TBIT_CYCLES(6), .TRESET_CYCLES(20)) dut3 (
    .clk_in(clk), .rst_in(rst_n), .start_in(start3), .pat_if(if3),
    .strand_out(s3), .busy_out(b3), .frame_done_out(d3), .underrun_out(u3));

  ws2812_driver #(.NUM_LEDS(1), .COLOR_WIDTH(8), .T0H_CYCLES(2), .T1H_CYCLES(4),
                  .TBIT_CYCLES(6), .TRESET_CYCLES(20)) dut1 (
    .clk_in(clk), .rst_in(rst_n), .start_in(start1), .pat_if(if1),
    .strand_out(s1), .busy_out(b1), .frame_done_out(d1), .underrun_out(u1));

  // Pattern sources with one registered cycle of latency
  always @(posedge clk) begin
    if3.green_in       <= 8'd0;
    if3.red_in         <= 8'(int'(if3.next_led_request) * 4);
    if3.blue_in        <= 8'(255 - int'(if3.next_led_request) * 4);
    if3.color_valid_in <= valid_en3;
    if1.green_in       <= g1;
    if1.red_in         <= r1;
    if1.blue_in        <= bl1;
    if1.color_valid_in <= valid_en1;
  end

  always @(negedge clk) if (if1.next_led_request !== 1'b0) req1_bad++;

  function automatic logic strand_of(input int sel); return (sel != 0) ? s1 : s3; endfunction
  function automatic logic busy_of(input int sel);   return (sel != 0) ? b1 : b3; endfunction
  function automatic logic done_of(input int sel);   return (sel != 0) ? d1 : d3; endfunction
  function automatic logic ur_of(input int sel);     return (sel != 0) ? u1 : u3; endfunction

  // Wait for the first rising edge, then record nbits*6 samples of the strand
  task automatic grab(input int sel, input int nbits, output int found);
    found = 0; rise_lat = 0; busy_low = 0; ur_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (strand_of(sel)) begin found = 1; break; end
      @(negedge clk); rise_lat++;
    end
    if (found != 0) begin
      for (int i = 0; i < nbits * 6; i++) begin
        if (i > 0) @(negedge clk);
        wave[i] = strand_of(sel);
        if (!busy_of(sel)) busy_low++;
        if (ur_of(sel)) ur_cnt++;
      end
    end
  endtask

  task automatic decode(input int nleds);
    logic [5:0] seg;
    logic [23:0] word;
    bad_bits = 0;
    for (int l = 0; l < nleds; l++) begin
      word = '0;
      for (int b = 0; b < 24; b++) begin
        seg = '0;
        for (int c = 0; c < 6; c++) seg = {seg[4:0], wave[(l*24+b)*6+c]};
        if (seg == 6'b111100)      word = {word[22:0], 1'b1};
        else if (seg == 6'b110000) word = {word[22:0], 1'b0};
        else begin bad_bits++; word = {word[22:0], 1'b0}; end
      end
      led_word[l] = word;
    end
  endtask

  task automatic wait_done(input int sel, output int got, output int lo, output int hi);
    got = 0; lo = 0; hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_of(sel)) begin got = 1; break; end
      if (strand_of(sel)) hi++; else lo++;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({s3, b3, d3, u3} !== 4'b0) begin errors++; $display("FAIL reset_out3: got %b want 0000", {s3, b3, d3, u3}); end
    checks++; if (if3.next_led_request !== 2'd0) begin errors++; $display("FAIL reset_req3: got %0d want 0", if3.next_led_request); end
    checks++; if ({s1, b1, d1, u1} !== 4'b0) begin errors++; $display("FAIL reset_out1: got %b want 0000", {s1, b1, d1, u1}); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if ({s3, b3} !== 2'b00) begin errors++; $display("FAIL idle_after_reset: got %b want 00", {s3, b3}); end
  endtask

  task automatic test_gradient();
    int found, got, lo, hi;
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    grab(0, 72, found);
    checks++; if (found != 1) begin errors++; $display("FAIL grad_rise: got %0d want 1", found); end
    checks++; if (rise_lat < 3 || rise_lat > 6) begin errors++; $display("FAIL grad_latency: got %0d want 3..6", rise_lat); end
    decode(3);
    checks++; if (led_word[0] !== 24'h0000FF) begin errors++; $display("FAIL grad_led0: got %h want 0000ff", led_word[0]); end
    checks++; if (led_word[1] !== 24'h0004FB) begin errors++; $display("FAIL grad_led1: got %h want 0004fb", led_word[1]); end
    checks++; if (led_word[2] !== 24'h0008F7) begin errors++; $display("FAIL grad_led2: got %h want 0008f7", led_word[2]); end
    checks++; if (bad_bits != 0) begin errors++; $display("FAIL grad_bitshape: got %0d bad want 0", bad_bits); end
    checks++; if (busy_low != 0 || ur_cnt != 0) begin errors++; $display("FAIL grad_busy_ur: got %0d/%0d want 0/0", busy_low, ur_cnt); end
    wait_done(0, got, lo, hi);
    checks++; if (got != 1 || lo != 20 || hi != 0) begin errors++; $display("FAIL grad_gap: got done=%0d lo=%0d hi=%0d want 1/20/0", got, lo, hi); end
    checks++; if (b3 !== 1'b0) begin errors++; $display("FAIL grad_busy_at_done: got %b want 0", b3); end
    @(negedge clk);
    checks++; if ({d3, b3} !== 2'b00 || if3.next_led_request !== 2'd0) begin
      errors++; $display("FAIL grad_after_done: got done=%b busy=%b req=%0d want 0/0/0", d3, b3, if3.next_led_request); end
  endtask

  task automatic test_single();
    int found, got, lo, hi;
    g1 = 8'h80; r1 = 8'h00; bl1 = 8'h00; req1_bad = 0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    grab(1, 24, found);
    decode(1);
    checks++; if (found != 1 || led_word[0] !== 24'h800000) begin errors++; $display("FAIL single_word: got %h want 800000", led_word[0]); end
    checks++; if (bad_bits != 0) begin errors++; $display("FAIL single_bitshape: got %0d bad want 0", bad_bits); end
    checks++; if (busy_low != 0) begin errors++; $display("FAIL single_busy: got %0d low want 0", busy_low); end
    wait_done(1, got, lo, hi);
    checks++; if (got != 1 || lo != 20 || hi != 0) begin errors++; $display("FAIL single_gap: got done=%0d lo=%0d hi=%0d want 1/20/0", got, lo, hi); end
    checks++; if (req1_bad != 0) begin errors++; $display("FAIL single_req: got %0d nonzero want 0", req1_bad); end
  endtask

  task automatic test_underrun();
    int found, ur_idx, ur_total, done_idx, hi_after, idle_bad;
    found = 0; ur_idx = -1; ur_total = 0; done_idx = -1; hi_after = 0; idle_bad = 0;
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (s3) begin found = 1; break; end
      @(negedge clk);
    end
    valid_en3 = 1'b0;
    for (int i = 0; i < 400 && found == 1 && done_idx < 0; i++) begin
      if (i > 0) @(negedge clk);
      if (u3) begin ur_total++; if (ur_idx < 0) ur_idx = i; end
      if (d3) done_idx = i;
      if (ur_idx >= 0 && s3) hi_after++;
    end
    checks++; if (ur_idx != 144 || ur_total != 1) begin errors++; $display("FAIL underrun_pulse: got at=%0d n=%0d want 144/1", ur_idx, ur_total); end
    checks++; if (done_idx != 164 || hi_after != 0) begin errors++; $display("FAIL underrun_gap: got done=%0d hi=%0d want 164/0", done_idx, hi_after); end
    checks++; if (b3 !== 1'b0) begin errors++; $display("FAIL underrun_busy: got %b want 0", b3); end
    valid_en3 = 1'b1;
    repeat (5) begin @(negedge clk); if (b3 || s3) idle_bad++; end
    checks++; if (idle_bad != 0) begin errors++; $display("FAIL underrun_idle: got %0d active want 0", idle_bad); end
  endtask

  task automatic test_back_to_back();
    int rises, blow, n, got;
    logic prev;
    @(negedge clk); start3 = 1'b1;
    for (int f = 0; f < 2; f++) begin
      rises = 0; blow = 0; n = 0; got = 0; prev = s3;
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk); n++;
        if (s3 && !prev) rises++;
        prev = s3;
        if (d3) begin got = 1; break; end
        if (!b3) blow++;
      end
      checks++; if (got != 1 || rises != 72) begin errors++; $display("FAIL b2b_frame%0d: got done=%0d rises=%0d want 1/72", f, got, rises); end
      checks++; if (blow != 0 || b3 !== 1'b0) begin errors++; $display("FAIL b2b_busy%0d: got low=%0d busy_at_done=%b want 0/0", f, blow, b3); end
      if (f == 0) begin
        checks++; if (n - 1 < 455 || n - 1 > 465) begin errors++; $display("FAIL b2b_duration: got %0d want 455..465", n - 1); end
        @(negedge clk);
        checks++; if (b3 !== 1'b1) begin errors++; $display("FAIL b2b_restart: got %b want 1", b3); end
        start3 = 1'b0;
      end
    end
  endtask

  task automatic test_async_reset();
    int found, bad, got, lo, hi;
    found = 0; bad = 0;
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (s3) begin found = 1; break; end
      @(negedge clk);
    end
    checks++; if (found != 1 || b3 !== 1'b1 || if3.next_led_request !== 2'd1) begin
      errors++; $display("FAIL arst_pre: got rise=%0d busy=%b req=%0d want 1/1/1", found, b3, if3.next_led_request); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({s3, b3} !== 2'b00 || if3.next_led_request !== 2'd0) begin
      errors++; $display("FAIL arst_async: got strand=%b busy=%b req=%0d want 0/0/0", s3, b3, if3.next_led_request); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) begin @(negedge clk); if (d3 || b3 || s3) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL arst_idle: got %0d active cycles want 0", bad); end
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    grab(0, 72, found);
    decode(3);
    checks++; if (found != 1 || led_word[0] !== 24'h0000FF || led_word[2] !== 24'h0008F7) begin
      errors++; $display("FAIL arst_restart: got %h/%h want 0000ff/0008f7", led_word[0], led_word[2]); end
    wait_done(0, got, lo, hi);
    checks++; if (got != 1 || lo != 20) begin errors++; $display("FAIL arst_done: got done=%0d lo=%0d want 1/20", got, lo); end
  endtask

  initial begin
    test_reset();
    test_gradient();
    test_single();
    test_underrun();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
